// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction handshake, register load port, ALU operand/result and writeback status.
interface alu_issue_if;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_operand1;
    logic [7:0] alu_operand2;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       zero_q;

    modport slave (
        input  instr_valid, instr, ld_valid, ld_addr, ld_data, alu_result, alu_zero,
        output instr_ready, alu_operand1, alu_operand2, alu_op, wb_valid, wb_rd, wb_data, zero_q
    );

    modport master (
        output instr_valid, instr, ld_valid, ld_addr, ld_data, alu_result, alu_zero,
        input  instr_ready, alu_operand1, alu_operand2, alu_op, wb_valid, wb_rd, wb_data, zero_q
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage with 4x8 register file feeding an external ALU and writing its result back.
// Optional macro ALU_ISSUE_FWD_EN: forward alu_result on a distance-1 hazard instead of stalling.
module alu_issue_stage (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned OP_W     = 2;
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(3);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] operand1_q, operand1_d;
    logic [DATA_W-1:0] operand2_q, operand2_d;
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              zero_flag_q, zero_flag_d;

    logic [OP_W-1:0]   id_op;
    logic [ADDR_W-1:0] id_rd, id_rs1, id_rs2;
    logic              hazard1_c, hazard2_c, stall_c, ready_c, accept_c;

    assign {id_op, id_rd, id_rs1, id_rs2} = bus.instr;

    // Distance-1 dependence on the instruction currently in EX; NOT has no rs2 source.
    always_comb begin
        hazard1_c = ex_valid_q && (id_rs1 == ex_rd_q);
        hazard2_c = ex_valid_q && (id_op != OP_NOT) && (id_rs2 == ex_rd_q);
`ifdef ALU_ISSUE_FWD_EN
        stall_c   = 1'b0;
`else
        stall_c   = hazard1_c || hazard2_c;
`endif
        ready_c   = rst_n && !bus.ld_valid && !stall_c;
        accept_c  = bus.instr_valid && ready_c;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        ex_valid_d  = accept_c;
        ex_rd_d     = ex_rd_q;
        alu_op_d    = alu_op_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        zero_flag_d = zero_flag_q;

        if (accept_c) begin
            ex_rd_d    = id_rd;
            alu_op_d   = id_op;
            operand1_d = regs_q[id_rs1];
            operand2_d = regs_q[id_rs2];
`ifdef ALU_ISSUE_FWD_EN
            if (hazard1_c) operand1_d = bus.alu_result;
            if (hazard2_c) operand2_d = bus.alu_result;
`endif
        end

        if (ex_valid_q) begin
            regs_d[ex_rd_q] = bus.alu_result;
            zero_flag_d     = bus.alu_zero;
            wb_valid_d      = 1'b1;
            wb_rd_d         = ex_rd_q;
            wb_data_d       = bus.alu_result;
        end

        // Load is applied last so it wins over a same-register writeback.
        if (bus.ld_valid) begin
            regs_d[bus.ld_addr] = bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            alu_op_q    <= '0;
            operand1_q  <= '0;
            operand2_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            zero_flag_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            alu_op_q    <= alu_op_d;
            operand1_q  <= operand1_d;
            operand2_q  <= operand2_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            zero_flag_q <= zero_flag_d;
        end
    end

    assign bus.instr_ready  = ready_c;
    assign bus.alu_operand1 = operand1_q;
    assign bus.alu_operand2 = operand2_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.zero_q       = zero_flag_q;
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/operand-issue stage directly upstream of the 8-bit ALU, with the ALU writeback register immediately downstream of it. It accepts 8-bit register-to-register instructions over a valid/ready handshake and reads a 4×8 register file. It drives registered `operand1`/`operand2`/`alu_op` into the ALU, then writes the ALU `result` back and latches `zero_flag`. A side load port lets the memory stage or bench write registers directly.

## Interface
- No parameters. Fixed: 8-bit data, 4 registers, 8-bit instruction.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `instr_valid` in 1: `instr` holds a valid instruction.
- `instr` in 8: [7:6] alu_op, [5:4] rd, [3:2] rs1, [1:0] rs2.
- `instr_ready` out 1: stage accepts `instr` this cycle.
- `ld_valid` in 1: write `ld_data` to register `ld_addr` at this edge.
- `ld_addr` in 2: load target register.
- `ld_data` in 8: load value.
- `alu_operand1` out 8: registered rs1 value, to ALU `operand1`.
- `alu_operand2` out 8: registered rs2 value, to ALU `operand2`.
- `alu_op` out 2: registered opcode, to ALU `alu_op`.
- `alu_result` in 8: ALU `result`, combinational from the outputs above.
- `alu_zero` in 1: ALU `zero_flag`.
- `wb_valid` out 1: one-cycle pulse; ALU writeback done last edge.
- `wb_rd` out 2: register written by that writeback.
- `wb_data` out 8: value written by that writeback.
- `zero_q` out 1: zero flag of the most recent ALU writeback.

## Operation
- Pipeline:
  - ID: accept, read the register file, capture into EX registers.
  - EX: ALU evaluates combinationally; next edge writes back.
- Accept condition: `instr_valid && instr_ready` at an edge. Latches `ex_valid`=1, `alu_op`, `ex_rd`, and both operands.
- `alu_op` 2'b11 (NOT) uses rs1 only; `rs2` is ignored for hazard checks. `alu_operand2` is still loaded with `R[rs2]`.
- Writeback happens at the edge after acceptance when `ex_valid`=1. It updates `R[ex_rd]`=`alu_result`, `zero_q`=`alu_zero`, `wb_valid`=1, `wb_rd`, and `wb_data`.
- No accept ⇒ `ex_valid`=0 (bubble). A bubble performs no writeback, and `zero_q` holds.
- Hazard: `ex_valid` and ID rs1 (or rs2, when not NOT) == `ex_rd`. Handling is set by `ALU_ISSUE_FWD_EN`, see Configuration.
- `instr_ready` = `rst_n && !ld_valid && !stall`. It is combinational from inputs and state.
- Load port:
  - `ld_valid` blocks acceptance that cycle and writes `R[ld_addr]` at the edge.
  - If an EX writeback hits the same register at the same edge, the load value wins. `wb_valid`/`wb_data` still report the ALU value.
  - A load to a different register alongside a writeback: both writes occur.
  - A load never changes `zero_q`.
- Reset (`rst_n`=0 at an edge):
  - R0–R3=0; `ex_valid`, `alu_operand1/2`, `alu_op`, `wb_valid`, `wb_rd`, `wb_data`, `zero_q` all =0.
  - An in-flight EX instruction is discarded with no writeback.
  - `instr_ready`=0 while `rst_n`=0.

## Timing
- Instruction accepted at edge E0:
  - operands/op valid in the cycle after E0;
  - R[rd] written at E1;
  - `wb_valid`=1 in the cycle after E1.
- Latency: 2 edges from accept to architectural update.
- Throughput: 1 instr/cycle when there is no hazard and no load.
- Register reads are combinational from register state before the edge. Back-to-back dependence (distance 1) is the only hazard; distance ≥2 reads the updated file.
- `wb_valid` is high for exactly one cycle per writeback.

## Configuration
- `ALU_ISSUE_FWD_EN` defined:
  - On a hazard, `alu_result` is muxed into the matching operand capture.
  - `stall`=0 always.
  - Dependent pairs issue back-to-back.
- `ALU_ISSUE_FWD_EN` undefined:
  - `stall`=hazard, dropping `instr_ready` for one cycle.
  - EX bubbles; the instruction is accepted the next cycle and reads the written file.
  - Each dependent pair costs 1 cycle.

## Test plan
- **Reset:** hold `rst_n`=0 2 cycles with `instr_valid`=1 → `instr_ready`=0, all outputs 0. Release, issue OR r0,r0→r1 → `wb_data`=00, `zero_q`=1.
- **Loads + AND:** load R1=F0, R2=3C; issue AND rd=3,rs1=1,rs2=2 (instr 8'h36) → `alu_operand1`=F0, `alu_operand2`=3C, `wb_rd`=3, `wb_data`=30, `zero_q`=0, 2 edges after accept.
- **Back-to-back dependence:** R1=0F; issue NOT r1→r2 (8'hE4) then XOR r2,r1→r3 (8'hB9) consecutively.
  - Required: R3=FF, `zero_q`=0.
  - With FWD_EN: accepted on consecutive edges.
  - Without FWD_EN: `instr_ready` low exactly 1 cycle.
- **Load/writeback collision:** EX writing R1 while `ld_valid` R1=55 → R1=55, `wb_valid`=1 with ALU value, `instr_ready`=0 that cycle.
- **Zero flag:** R1=AA, R2=AA; XOR r1,r2→r0 → `wb_data`=00, `zero_q`=1. Then load R0=01 → `zero_q` stays 1.
- **Mid-op reset:** accept an instruction, then assert `rst_n`=0 at the next edge → no `wb_valid`, target register reads 0 afterward.
